// File: rtl/merge_pass_scheduler_pkg.sv
// Shared types and defaults for the merge-pass scheduler: state encoding,
// datapath widths and the default run/pass limits.
package merge_pass_scheduler_pkg;

  localparam int unsigned LEN_W          = 32;
  localparam int unsigned PASS_W         = 6;
  localparam int unsigned RUN_INIT_DEF   = 16;
  localparam int unsigned MAX_PASSES_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_SORT,
    ST_SORT,
    ST_CHECK,
    ST_CLR_MERGE,
    ST_MERGE,
    ST_SWAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/merge_pass_scheduler.sv
// Sequences one sort phase followed by ping-pong merge passes, doubling the
// sorted-run length each pass until it covers the stream or the pass limit hits.
module merge_pass_scheduler
  import merge_pass_scheduler_pkg::*;
#(
  parameter int unsigned RUN_INIT   = RUN_INIT_DEF,
  parameter int unsigned MAX_PASSES = MAX_PASSES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic [LEN_W-1:0]  stream_len_in,
  input  logic              sort_done_in,
  input  logic              merge_done_in,
  output logic              phase_clear_out,
  output logic              sort_en_out,
  output logic              merge_en_out,
  output logic [LEN_W-1:0]  run_len_out,
  output logic              src_bank_out,
  output logic [PASS_W-1:0] pass_cnt_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              overflow_out
);

  localparam logic [LEN_W-1:0] RUN_SAT = LEN_W'(1) << (LEN_W - 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   stream_len_q;
  logic [LEN_W-1:0]   run_len_q;
  logic [PASS_W-1:0]  pass_cnt_q;
  logic               src_bank_q;
  logic               overflow_q;

  logic               start_acc_c;
  logic               covered_c;
  logic               at_limit_c;
  logic [LEN_W-1:0]   run_dbl_c;

  assign start_acc_c = start_in && (state_q == ST_IDLE || state_q == ST_DONE);
  assign covered_c   = run_len_q >= stream_len_q;
  assign at_limit_c  = pass_cnt_q == PASS_W'(MAX_PASSES);
  assign run_dbl_c   = run_len_q[LEN_W-1] ? RUN_SAT : (run_len_q << 1);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done levels are only looked at in their own phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_in) state_d = ST_CLR_SORT;
      ST_CLR_SORT:      state_d = ST_SORT;
      ST_SORT:          if (sort_done_in) state_d = ST_CHECK;
      ST_CHECK: begin
        if (covered_c || at_limit_c) state_d = ST_DONE;
        else                         state_d = ST_CLR_MERGE;
      end
      ST_CLR_MERGE:     state_d = ST_MERGE;
      ST_MERGE:         if (merge_done_in) state_d = ST_SWAP;
      ST_SWAP:          state_d = ST_CHECK;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Stream parameters and pass bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stream_len_q <= '0;
      run_len_q    <= LEN_W'(RUN_INIT);
      pass_cnt_q   <= '0;
      src_bank_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (start_acc_c) begin
      stream_len_q <= stream_len_in;
      run_len_q    <= LEN_W'(RUN_INIT);
      pass_cnt_q   <= '0;
      src_bank_q   <= 1'b1;
      overflow_q   <= 1'b0;
    end else if (state_q == ST_SWAP) begin
      run_len_q    <= run_dbl_c;
      pass_cnt_q   <= pass_cnt_q + PASS_W'(1);
      src_bank_q   <= ~src_bank_q;
    end else if (state_q == ST_CHECK && !covered_c && at_limit_c) begin
      overflow_q   <= 1'b1;
    end
  end

  // Phase controls registered from the next state so they align with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_clear_out <= 1'b0;
      sort_en_out     <= 1'b0;
      merge_en_out    <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      phase_clear_out <= (state_d == ST_CLR_SORT) || (state_d == ST_CLR_MERGE);
      sort_en_out     <= state_d == ST_SORT;
      merge_en_out    <= state_d == ST_MERGE;
      busy_out        <= !((state_d == ST_IDLE) || (state_d == ST_DONE));
      done_out        <= state_d == ST_DONE;
    end
  end

  assign run_len_out  = run_len_q;
  assign src_bank_out = src_bank_q;
  assign pass_cnt_out = pass_cnt_q;
  assign overflow_out = overflow_q;

endmodule
